// File: rtl/game_flow_controller.sv
// Game sequencer for the frog-crossing game: owns lives, level and score,
// gates obstacle motion and returns the player to the start tile.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for the first start press after reset
// PLAY      | obstacles running, watching for collision / goal row
// HIT       | player struck, sprite flashing for the hit hold time
// GOAL      | crossing completed, short pause before the next run
// GAME_OVER | no lives left, score and level held until start
module game_flow_controller #(
   parameter int CLKS_PER_TICK   = 25000,
   parameter int HIT_HOLD_TICKS  = 500,
   parameter int GOAL_HOLD_TICKS = 250,
   parameter int FLASH_TICKS     = 125,
   parameter int LIVES_INIT      = 3,
   parameter int MAX_LEVEL       = 9,
   parameter int GOAL_ROW        = 1
) (
   input  logic       i_Clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [4:0] i_player_x,
   input  logic [3:0] i_player_y,
   input  logic       i_collision,
   output logic       o_player_reset,
   output logic       o_obstacle_enable,
   output logic [3:0] o_level,
   output logic [1:0] o_lives,
   output logic [6:0] o_score,
   output logic [2:0] o_state,
   output logic       o_flash
);

   localparam int HOLD_MAX = (HIT_HOLD_TICKS > GOAL_HOLD_TICKS) ? HIT_HOLD_TICKS : GOAL_HOLD_TICKS;
   localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;

   localparam logic [PW-1:0] PRE_LAST   = PW'(CLKS_PER_TICK - 1);
   localparam logic [HW-1:0] HIT_LAST   = HW'(HIT_HOLD_TICKS - 1);
   localparam logic [HW-1:0] GOAL_LAST  = HW'(GOAL_HOLD_TICKS - 1);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);
   localparam logic [1:0]    LIVES_RST  = 2'(LIVES_INIT);
   localparam logic [3:0]    LEVEL_TOP  = 4'(MAX_LEVEL);
   localparam logic [3:0]    ROW_GOAL   = 4'(GOAL_ROW);
   localparam logic [6:0]    SCORE_TOP  = 7'd99;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PLAY      = 3'd1,
      HIT       = 3'd2,
      GOAL      = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   state_t          state;
   logic            r_start;
   logic [PW-1:0]   pre_cnt;
   logic [HW-1:0]   hold_cnt;
   logic [FW-1:0]   flash_cnt;
   logic            start_edge;
   logic            tick;
   logic            hold_done;
   logic            flash_flip;
   logic            x_bad;

   assign start_edge = i_start & ~r_start;
   assign tick       = (pre_cnt == PRE_LAST);
   assign hold_done  = tick && (((state == HIT) && (hold_cnt == HIT_LAST)) ||
                                ((state == GOAL) && (hold_cnt == GOAL_LAST)));
   assign flash_flip = tick && (flash_cnt == FLASH_LAST);
   // Wrapped or corrupted columns must not let the frog slip past obstacles.
   assign x_bad      = (i_player_x == 5'd0) || (i_player_x > 5'd20);
   assign o_state    = state;

   // Game FSM with hold timers and all registered outputs.
   always_ff @(posedge i_Clk) begin
      if (i_reset) begin
         state             <= IDLE;
         r_start           <= 1'b1;
         pre_cnt           <= '0;
         hold_cnt          <= '0;
         flash_cnt         <= '0;
         o_player_reset    <= 1'b0;
         o_obstacle_enable <= 1'b0;
         o_level           <= 4'd1;
         o_lives           <= LIVES_RST;
         o_score           <= 7'd0;
         o_flash           <= 1'b0;
      end else begin
         r_start        <= i_start;
         o_player_reset <= 1'b0;
         case (state)
            IDLE, GAME_OVER: begin
               if (start_edge) begin
                  state             <= PLAY;
                  o_player_reset    <= 1'b1;
                  o_obstacle_enable <= 1'b1;
                  o_lives           <= LIVES_RST;
                  o_level           <= 4'd1;
                  o_score           <= 7'd0;
                  pre_cnt           <= '0;
                  hold_cnt          <= '0;
                  flash_cnt         <= '0;
               end
            end
            PLAY: begin
               if (i_collision || x_bad) begin
                  state             <= HIT;
                  o_obstacle_enable <= 1'b0;
                  o_lives           <= o_lives - 2'd1;
                  o_flash           <= 1'b1;
                  pre_cnt           <= '0;
                  hold_cnt          <= '0;
                  flash_cnt         <= '0;
               end else if (i_player_y == ROW_GOAL) begin
                  state             <= GOAL;
                  o_obstacle_enable <= 1'b0;
                  if (o_score != SCORE_TOP) o_score <= o_score + 7'd1;
                  if (o_level != LEVEL_TOP) o_level <= o_level + 4'd1;
                  pre_cnt           <= '0;
                  hold_cnt          <= '0;
                  flash_cnt         <= '0;
               end
            end
            HIT, GOAL: begin
               if (hold_done) begin
                  o_flash   <= 1'b0;
                  pre_cnt   <= '0;
                  hold_cnt  <= '0;
                  flash_cnt <= '0;
                  if ((state == HIT) && (o_lives == 2'd0)) begin
                     state <= GAME_OVER;
                  end else begin
                     state             <= PLAY;
                     o_player_reset    <= 1'b1;
                     o_obstacle_enable <= 1'b1;
                  end
               end else begin
                  pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                  if (tick) begin
                     hold_cnt  <= hold_cnt + 1'b1;
                     flash_cnt <= flash_flip ? '0 : flash_cnt + 1'b1;
                     if (flash_flip && (state == HIT)) o_flash <= ~o_flash;
                  end
               end
            end
            default: begin
               state             <= IDLE;
               o_obstacle_enable <= 1'b0;
               o_flash           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller with short timer parameters.
// Stimulus pushes every expected output change; the monitor pops one entry
// whenever the DUT output vector changes (or a snapshot is requested).
module tb_game_flow_controller;

   logic       clk = 1'b0;
   logic       i_reset, i_start, i_collision;
   logic [4:0] i_player_x;
   logic [3:0] i_player_y;
   logic       o_player_reset, o_obstacle_enable, o_flash;
   logic [3:0] o_level;
   logic [1:0] o_lives;
   logic [6:0] o_score;
   logic [2:0] o_state;

   game_flow_controller #(
      .CLKS_PER_TICK(4), .HIT_HOLD_TICKS(3), .GOAL_HOLD_TICKS(2),
      .FLASH_TICKS(1), .LIVES_INIT(3), .MAX_LEVEL(9), .GOAL_ROW(1)
   ) dut (
      .i_Clk(clk), .i_reset(i_reset), .i_start(i_start),
      .i_player_x(i_player_x), .i_player_y(i_player_y),
      .i_collision(i_collision), .o_player_reset(o_player_reset),
      .o_obstacle_enable(o_obstacle_enable), .o_level(o_level),
      .o_lives(o_lives), .o_score(o_score), .o_state(o_state),
      .o_flash(o_flash)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [18:0] vec;
      int         gap;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic mon_en  = 1'b0;
   logic snap    = 1'b0;
   int   m_lives = 3;
   int   m_level = 1;
   int   m_score = 0;

   function automatic logic [18:0] pack(input int st, input int lv, input int lvl,
                                        input int sc, input int en, input int pr, input int fl);
      return {3'(st), 2'(lv), 4'(lvl), 7'(sc), 1'(en), 1'(pr), 1'(fl)};
   endfunction

   task automatic push(input string nm, input int st, input int en, input int pr,
                       input int fl, input int gap);
      exp_t e;
      e.name = nm;
      e.vec  = pack(st, m_lives, m_level, m_score, en, pr, fl);
      e.gap  = gap;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: compare each observed output change against the queue head.
   logic [18:0] prev_vec = '0;
   int          cyc_cnt  = 0;
   int          last_cyc = 0;
   always @(negedge clk) begin
      logic [18:0] cur;
      exp_t        e;
      cyc_cnt = cyc_cnt + 1;
      cur = {o_state, o_lives, o_level, o_score, o_obstacle_enable, o_player_reset, o_flash};
      if (mon_en && (cur != prev_vec || snap)) begin
         snap = 1'b0;
         n_tests = n_tests + 1;
         if (exp_q.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL unexpected_change: got state=%0d lives=%0d level=%0d score=%0d en=%0d prst=%0d flash=%0d, required no change",
                     o_state, o_lives, o_level, o_score, o_obstacle_enable, o_player_reset, o_flash);
         end else begin
            e = exp_q.pop_front();
            if (cur !== e.vec) begin
               n_fail = n_fail + 1;
               $display("FAIL %s: got state=%0d lives=%0d level=%0d score=%0d en=%0d prst=%0d flash=%0d, required state=%0d lives=%0d level=%0d score=%0d en=%0d prst=%0d flash=%0d",
                        e.name, o_state, o_lives, o_level, o_score, o_obstacle_enable, o_player_reset, o_flash,
                        e.vec[18:16], e.vec[15:14], e.vec[13:10], e.vec[9:3], e.vec[2], e.vec[1], e.vec[0]);
            end
            if (e.gap != 0) begin
               n_tests = n_tests + 1;
               if (cyc_cnt - last_cyc != e.gap) begin
                  n_fail = n_fail + 1;
                  $display("FAIL %s_timing: got %0d cycles, required %0d", e.name, cyc_cnt - last_cyc, e.gap);
               end
            end
         end
         last_cyc = cyc_cnt;
      end
      prev_vec = cur;
   end

   task automatic check_reset_values(input string nm);
      m_lives = 3; m_level = 1; m_score = 0;
      push(nm, 0, 0, 0, 0, 0);
      snap = 1'b1;
      cyc(2);
   endtask

   // From IDLE or GAME_OVER with i_start low.
   task automatic press_start(input string nm);
      i_start = 1'b1;
      m_lives = 3; m_level = 1; m_score = 0;
      push({nm, "_enter"}, 1, 1, 1, 0, 0);
      push({nm, "_pulse_end"}, 1, 1, 0, 0, 1);
      cyc(1);
      i_start = 1'b0;
      cyc(3);
   endtask

   // mode 0: collision, 1: collision on goal row, 2: out-of-range x
   task automatic hit(input string nm, input int mode, input logic [4:0] x);
      if (mode == 2) i_player_x = x;
      else i_collision = 1'b1;
      if (mode == 1) i_player_y = 4'd1;
      m_lives = m_lives - 1;
      push({nm, "_enter"}, 2, 0, 0, 1, 0);
      push({nm, "_flash0"}, 2, 0, 0, 0, 4);
      push({nm, "_flash1"}, 2, 0, 0, 1, 4);
      if (m_lives == 0) begin
         push({nm, "_game_over"}, 4, 0, 0, 0, 4);
      end else begin
         push({nm, "_resume"}, 1, 1, 1, 0, 4);
         push({nm, "_pulse_end"}, 1, 1, 0, 0, 1);
      end
      cyc(1);
      i_collision = 1'b0;
      i_player_x  = 5'd10;
      i_player_y  = 4'd8;
      cyc(14);
   endtask

   task automatic goal(input string nm);
      i_player_y = 4'd1;
      if (m_score < 99) m_score = m_score + 1;
      if (m_level < 9)  m_level = m_level + 1;
      push({nm, "_enter"}, 3, 0, 0, 0, 0);
      push({nm, "_resume"}, 1, 1, 1, 0, 8);
      push({nm, "_pulse_end"}, 1, 1, 0, 0, 1);
      cyc(1);
      i_player_y = 4'd8;
      cyc(10);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset = 1'b1; i_start = 1'b1; i_collision = 1'b0;
      i_player_x = 5'd10; i_player_y = 4'd8;
      cyc(3);
      i_reset = 1'b0;
      mon_en = 1'b1;
      check_reset_values("reset_state");
      cyc(5);
      check_reset_values("start_held_no_edge");
      i_start = 1'b0;
      cyc(2);
      press_start("start1");

      hit("hit1", 0, 5'd10);
      goal("goal1");
      hit("hit_vs_goal", 1, 5'd10);
      hit("hit3", 0, 5'd10);
      cyc(5);
      press_start("restart");

      hit("bad_x0", 2, 5'd0);
      // start edges while playing must be ignored
      i_start = 1'b1; cyc(2); i_start = 1'b0; cyc(2);

      for (int g = 0; g < 100; g++) goal("goal_run");
      hit("bad_x21", 2, 5'd21);

      // reset in the middle of a hit hold
      i_collision = 1'b1;
      m_lives = m_lives - 1;
      push("midhit_enter", 2, 0, 0, 1, 0);
      cyc(1);
      i_collision = 1'b0;
      cyc(2);
      i_reset = 1'b1;
      m_lives = 3; m_level = 1; m_score = 0;
      push("midhit_reset", 0, 0, 0, 0, 3);
      cyc(1);
      i_reset = 1'b0;
      cyc(6);

      n_tests = n_tests + 1;
      if (exp_q.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL queue_drained: got %0d pending, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
